// File: rtl/hack_cpu_pkg.sv
// Shared definitions for the Hack CPU: widths, instruction field positions,
// and C-instruction comp encodings (a bit followed by zx,nx,zy,ny,f,no).
package hack_cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;

    localparam int BIT_IS_C = 15;
    localparam int BIT_A    = 12;
    localparam int BIT_ZX   = 11;
    localparam int BIT_NX   = 10;
    localparam int BIT_ZY   = 9;
    localparam int BIT_NY   = 8;
    localparam int BIT_F    = 7;
    localparam int BIT_NO   = 6;
    localparam int BIT_DA   = 5;
    localparam int BIT_DD   = 4;
    localparam int BIT_DM   = 3;
    localparam int BIT_JLT  = 2;
    localparam int BIT_JEQ  = 1;
    localparam int BIT_JGT  = 0;

    localparam logic [6:0] COMP_D     = 7'b0_001100;
    localparam logic [6:0] COMP_A     = 7'b0_110000;
    localparam logic [6:0] COMP_M     = 7'b1_110000;
    localparam logic [6:0] COMP_D_P1  = 7'b0_011111;
    localparam logic [6:0] COMP_ZERO  = 7'b0_101010;
    localparam logic [6:0] COMP_NEG1  = 7'b0_111010;
    localparam logic [6:0] COMP_D_P_A = 7'b0_000010;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctl_t;

endpackage

// File: rtl/hack_cpu_alu.sv
// Team Hack ALU: conditional zero/invert of both operands, add or AND,
// optional result inversion, plus zero and negative flags.
module hack_cpu_alu
    import hack_cpu_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  alu_ctl_t          ctl,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] x_z, x_n, y_z, y_n, res;

    always_comb begin
        x_z = ctl.zx ? '0 : x;
        x_n = ctl.nx ? ~x_z : x_z;
        y_z = ctl.zy ? '0 : y;
        y_n = ctl.ny ? ~y_z : y_z;
        res = ctl.f ? (x_n + y_n) : (x_n & y_n);
        out = ctl.no ? ~res : res;
        zr  = (out == '0);
        ng  = out[DATA_W-1];
    end

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU: A/D/PC registers, instruction decode and jump logic
// around the shared ALU. One instruction retires per unstalled cycle.
module hack_cpu
    import hack_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] inM,
    input  logic              stall,
    output logic [DATA_W-1:0] outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              is_c;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr, alu_ng;
    logic              jump;
    logic [ADDR_W-1:0] pc_inc;
    alu_ctl_t          alu_ctl;
    logic              unused_bits;

    assign unused_bits = ^instruction[14:13];

    assign is_c    = instruction[BIT_IS_C];
    assign alu_ctl = alu_ctl_t'(instruction[BIT_ZX:BIT_NO]);
    assign alu_y   = instruction[BIT_A] ? inM : a_q;

    hack_cpu_alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .ctl (alu_ctl),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign jump = (instruction[BIT_JLT] & alu_ng)
                | (instruction[BIT_JEQ] & alu_zr)
                | (instruction[BIT_JGT] & ~alu_ng & ~alu_zr);

    assign pc_inc = pc_q + 1'b1;

    // Jump target is the A value from before this instruction's own dA write.
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (!stall) begin
            if (!is_c) begin
                a_d  = instruction;
                pc_d = pc_inc;
            end else begin
                if (instruction[BIT_DA]) a_d = alu_out;
                if (instruction[BIT_DD]) d_d = alu_out;
                pc_d = jump ? a_q[ADDR_W-1:0] : pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= '0;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & instruction[BIT_DM] & ~stall & reset_n;
    assign addressM = a_q[ADDR_W-1:0];
    assign pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: register loads, memory writes, jumps, stall,
// PC wrap and mid-run reset, with hand-computed expectations.
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instruction;
    logic [15:0] inM;
    logic        stall;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    int n_checks = 0;
    int n_fails  = 0;

    hack_cpu dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .inM         (inM),
        .stall       (stall),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Present an instruction, let it retire at the next edge, settle after it.
    task automatic run(input logic [15:0] instr);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    // Observe A or D through the ALU without clocking.
    task automatic peek_a(input string tag, input logic [15:0] exp);
        instruction = 16'hEC00;
        #1;
        check(tag, outM, exp);
    endtask

    task automatic peek_d(input string tag, input logic [15:0] exp);
        instruction = 16'hE300;
        #1;
        check(tag, outM, exp);
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        inM         = 16'h0000;
        instruction = 16'h0000;
        run(16'h1234);
        stall = 1'b1;
        run(16'hE308);
        stall = 1'b0;
        instruction = 16'hE308;
        #1;
        check("rst_writeM", {15'd0, writeM}, 16'h0000);
        check("rst_pc", {1'b0, pc}, 16'h0000);
        check("rst_addr", {1'b0, addressM}, 16'h0000);
        peek_a("rst_A", 16'h0000);
        peek_d("rst_D", 16'h0000);

        // Load D
        reset_n = 1'b1;
        run(16'h0005);
        check("ld_pc1", {1'b0, pc}, 16'h0001);
        check("ld_addr", {1'b0, addressM}, 16'h0005);
        instruction = 16'hEC10;
        #1;
        check("ld_writeM", {15'd0, writeM}, 16'h0000);
        check("ld_outM", outM, 16'h0005);
        run(16'hEC10);
        check("ld_pc2", {1'b0, pc}, 16'h0002);
        peek_d("ld_D", 16'h0005);

        // Memory write
        run(16'h0010);
        instruction = 16'hE308;
        #1;
        check("mw_writeM", {15'd0, writeM}, 16'h0001);
        check("mw_addr", {1'b0, addressM}, 16'h0010);
        check("mw_outM", outM, 16'h0005);
        run(16'hE308);
        check("mw_pc", {1'b0, pc}, 16'h0004);

        // Stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction = 16'hE308;
            #1;
            check("st_writeM", {15'd0, writeM}, 16'h0000);
            run(16'hE308);
            check("st_pc", {1'b0, pc}, 16'h0004);
            check("st_addr", {1'b0, addressM}, 16'h0010);
        end
        stall = 1'b0;
        instruction = 16'hE308;
        #1;
        check("st_rel_writeM", {15'd0, writeM}, 16'h0001);
        run(16'hE308);
        check("st_rel_pc", {1'b0, pc}, 16'h0005);
        stall = 1'b1;
        run(16'hE7F0);
        stall = 1'b0;
        check("st_hold_pc", {1'b0, pc}, 16'h0005);
        peek_a("st_hold_A", 16'h0010);
        peek_d("st_hold_D", 16'h0005);

        // Jumps
        run(16'h0003);
        run(16'hEC10);
        run(16'h0020);
        run(16'hE301);
        check("jgt_taken", {1'b0, pc}, 16'h0020);
        run(16'h0000);
        run(16'hEC10);
        run(16'h0020);
        run(16'hE301);
        check("jgt_not", {1'b0, pc}, 16'h0024);
        run(16'hEA87);
        check("jmp", {1'b0, pc}, 16'h0020);

        // ALU comps with A=0x0020, D=0
        inM = 16'hBEEF;
        instruction = 16'hFC00; #1; check("alu_M", outM, 16'hBEEF);
        instruction = 16'hEC00; #1; check("alu_A", outM, 16'h0020);
        instruction = 16'hEA80; #1; check("alu_0", outM, 16'h0000);
        instruction = 16'hEE80; #1; check("alu_m1", outM, 16'hFFFF);
        instruction = 16'hE080; #1; check("alu_DpA", outM, 16'h0020);
        instruction = 16'hE7C0; #1; check("alu_Dp1", outM, 16'h0001);

        // AMD=D+1 writes memory at the old A
        instruction = 16'hE7F8;
        #1;
        check("amd_writeM", {15'd0, writeM}, 16'h0001);
        check("amd_addr", {1'b0, addressM}, 16'h0020);
        run(16'hE7F8);
        check("amd_newA", {1'b0, addressM}, 16'h0001);
        peek_d("amd_D", 16'h0001);

        // A=0;JMP jumps to the old A
        run(16'h0030);
        run(16'hEAA7);
        check("jmp_oldA_pc", {1'b0, pc}, 16'h0030);
        check("jmp_oldA_A", {1'b0, addressM}, 16'h0000);

        // PC wrap
        run(16'h7FFF);
        run(16'hEA87);
        check("wrap_at", {1'b0, pc}, 16'h7FFF);
        run(16'hE300);
        check("wrap_pc", {1'b0, pc}, 16'h0000);

        // JLT taken on negative, JEQ not taken
        run(16'h0040);
        run(16'hEE90);
        run(16'hE304);
        check("jlt_taken", {1'b0, pc}, 16'h0040);
        run(16'hE302);
        check("jeq_not", {1'b0, pc}, 16'h0041);

        // Reset mid-run
        run(16'h1234);
        run(16'hEC10);
        peek_d("pre_rst_D", 16'h1234);
        reset_n = 1'b0;
        instruction = 16'hE308;
        #1;
        check("mid_rst_writeM", {15'd0, writeM}, 16'h0000);
        run(16'hE308);
        check("mid_rst_pc", {1'b0, pc}, 16'h0000);
        check("mid_rst_addr", {1'b0, addressM}, 16'h0000);
        peek_a("mid_rst_A", 16'h0000);
        peek_d("mid_rst_D", 16'h0000);
        reset_n = 1'b1;
        run(16'h0007);
        check("post_rst_pc", {1'b0, pc}, 16'h0001);
        check("post_rst_addr", {1'b0, addressM}, 16'h0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clk and reset_n.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- instruction  in  16  current instruction word at address pc
- inM  in  16  data memory read data at addressM, combinational
- stall  in  1  freeze the processor this cycle
- outM  out  16  ALU result, write data
- writeM  out  1  data memory write strobe for this cycle
- addressM  out  15  data address, equal to A[14:0]
- pc  out  15  instruction address

Function
REQ-003 Architectural state SHALL be three registers: A (16 bits), D (16 bits) and PC (15 bits).
REQ-004 If instruction[15]=0 (A-instruction), the block SHALL load A with instruction at the next edge, leave D unchanged and set PC to PC+1.
REQ-005 If instruction[15]=1 (C-instruction), the block SHALL decode the fields as follows:
- a = bit 12
- zx,nx,zy,ny,f,no = bits 11..6
- dA,dD,dM = bits 5..3
- jlt,jeq,jgt = bits 2..0
- bits 14..13 ignored
REQ-006 The ALU x operand SHALL be D; the y operand SHALL be inM when a=1 and A otherwise.
REQ-007 ALU semantics SHALL be the team ALU's, applied in this order:
- zero x, then invert x
- zero y, then invert y
- f=1 gives 16-bit add with carry out dropped; f=0 gives bitwise AND
- no inverts the result
- zr = (out==0); ng = out[15]
REQ-008 outM SHALL equal the ALU result in every cycle, combinationally; its value is don't-care when writeM=0.
REQ-009 writeM SHALL be 1 only when the instruction is a C-instruction, dM=1, stall=0 and reset_n=1.
REQ-010 addressM SHALL reflect A before the edge, so M and A destinations in one instruction write memory at the old A.
REQ-011 At the edge, dA SHALL load the ALU result into A and dD SHALL load it into D; both are allowed in one instruction.
REQ-012 The jump condition SHALL be (jlt&ng) | (jeq&zr) | (jgt&~ng&~zr).
- Taken: PC <= old A[14:0], the value before any dA update in the same cycle.
- Otherwise: PC <= PC+1.
REQ-013 PC+1 SHALL wrap from 0x7FFF to 0x0000.
REQ-014 When stall=1, A, D and PC SHALL hold their values, and outM, addressM and pc SHALL continue to reflect the held state.
REQ-015 Latency SHALL be one instruction per unstalled cycle, with results visible at the next edge; there SHALL be no internal pipeline and no hazards.

Reset
REQ-016 When reset_n=0 at a rising edge, A, D and PC SHALL become 0 at that edge regardless of stall or instruction.
REQ-017 While reset_n=0, writeM SHALL be 0; pc, addressM and outM SHALL follow the register contents.
REQ-018 Reset asserted mid-program SHALL abandon the current instruction, and execution SHALL restart at pc=0 in the first cycle with reset_n=1.

Structure
REQ-019 A shared package SHALL hold:
- instruction field bit positions
- widths: DATA_W=16, ADDR_W=15
- C-instruction comp encodings used by the bench (D, A, M, D+1, 0, -1, D+A)
REQ-020 The datapath SHALL instantiate the existing ALU module as its single sub-module; the remaining decode, register, PC and jump logic SHALL be local to hack_cpu.

Verification
REQ-021 Load D: after reset, feed 0x0005 then 0xEC10 (D=A) -> D=5, pc=2, writeM=0 throughout.
REQ-022 Memory write: with D=5, feed 0x0010 then 0xE308 (M=D) -> in the second cycle writeM=1, addressM=0x0010, outM=0x0005.
REQ-023 Jumps:
- A=0x0020, D=3, instruction 0xE301 (D;JGT) -> pc=0x0020 next cycle.
- Same with D=0 -> pc increments.
- 0xEA87 (0;JMP) -> always taken.
REQ-024 Stall: assert stall=1 for 3 cycles with 0xE308 present -> writeM=0, A, D and pc unchanged; on release the instruction executes once.
REQ-025 Reset and wrap:
- Force PC to 0x7FFF via A=0x7FFF and 0;JMP, then execute a non-jump -> pc=0x0000.
- Assert reset_n=0 mid-run -> A=D=pc=0 at the next edge and writeM=0 while low.
